// File: rtl/down_link_pkg.sv
// Shared definitions for the downlink command channel: frame type codes,
// short-frame codes, command payload values, frame lengths and FSM states.
package down_link_pkg;

  localparam logic [3:0] TYPE_REF  = 4'b1001;
  localparam logic [3:0] TYPE_CMD  = 4'b1010;
  localparam logic [3:0] TYPE_FRE  = 4'b1011;

  localparam logic [3:0] CODE_SYN  = 4'b1000;
  localparam logic [3:0] CODE_LOCK = 4'b1100;

  localparam logic [15:0] CMD_START = 16'h1111;
  localparam logic [15:0] CMD_STOP  = 16'h2222;
  localparam logic [15:0] CMD_RST   = 16'h4444;
  localparam logic [15:0] CMD_PASS  = 16'h6666;
  localparam logic [15:0] CMD_CHECK = 16'h8888;

  localparam int LONG_BITS       = 22;
  localparam int SHORT_BITS      = 6;
  localparam int LONG_DATA_BITS  = LONG_BITS - 2;
  localparam int SHORT_DATA_BITS = SHORT_BITS - 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_GAP
  } tx_state_t;

  // Short codes sit in the top nibble so both frame kinds shift out from bit 19.
  function automatic logic [19:0] long_word(input logic [3:0] typ, input logic [15:0] payload);
    return {typ, payload};
  endfunction

  function automatic logic [19:0] short_word(input logic [3:0] code);
    return {code, 16'h0000};
  endfunction

endpackage

// File: rtl/down_bit_timer.sv
// Serial bit timer: counts 0..BIT_CYCLES-1 and flags the last cycle of a bit.
// clr restarts the count so a new state always begins on a full bit.
module down_bit_timer #(
  parameter int BIT_CYCLES = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (clr || tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign tick = (cnt_reg == CNT_LAST);

endmodule

// File: rtl/down_frame_tx.sv
// Downlink serial transmitter: arbitrates requests, frames words/codes and
// shifts them out on an idle-high line. DOWN_TX_REPEAT_EN repeats data words.
module down_frame_tx
  import down_link_pkg::*;
#(
  parameter int BIT_CYCLES = 100,
  parameter int GAP_BITS   = 2,
  parameter int REPEAT_N   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ref_req,
  input  logic [15:0] ref_data,
  input  logic        cmd_req,
  input  logic [15:0] cmd_data,
  input  logic        fre_req,
  input  logic [15:0] fre_data,
  input  logic        syn_req,
  input  logic        lock_req,
  output logic        txd,
  output logic        busy,
  output logic        ref_ack,
  output logic        cmd_ack,
  output logic        fre_ack,
  output logic        syn_ack,
  output logic        lock_ack,
  output logic        word_done
);

  localparam logic [4:0] GAP_LAST   = 5'(GAP_BITS - 1);
  localparam logic [4:0] LONG_LAST  = 5'(LONG_DATA_BITS - 1);
  localparam logic [4:0] SHORT_LAST = 5'(SHORT_DATA_BITS - 1);
`ifdef DOWN_TX_REPEAT_EN
  localparam logic [1:0] LONG_REP_LAST = 2'(REPEAT_N - 1);
`else
  // Single transmission; REPEAT_N stays in the parameter list for both builds.
  localparam logic [1:0] LONG_REP_LAST = 2'(REPEAT_N * 0);
`endif

  tx_state_t   state_reg, state_next;
  logic [4:0]  bit_reg, bit_next;
  logic [19:0] data_reg, data_next;
  logic        long_reg, long_next;
  logic [1:0]  rep_reg, rep_next;
  logic        txd_reg, txd_next;

  logic        bit_tick;
  logic        timer_clr;
  logic        accept;
  logic [4:0]  req_vec;
  logic [5:0]  higher;
  logic [4:0]  grant;
  logic [19:0] sel_word;
  logic [4:0]  data_last;
  logic [1:0]  rep_last;

  // Index 4 is highest priority: lock > syn > cmd > ref > fre.
  assign req_vec   = {lock_req, syn_req, cmd_req, ref_req, fre_req};
  assign higher[5] = 1'b0;

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_arb
      assign higher[gi] = higher[gi+1] | req_vec[gi];
      assign grant[gi]  = req_vec[gi] & ~higher[gi+1];
    end
  endgenerate

  assign accept = (state_reg == ST_IDLE) && !rst && (|req_vec);
  assign {lock_ack, syn_ack, cmd_ack, ref_ack, fre_ack} = accept ? grant : 5'b00000;

  always_comb begin
    sel_word = long_word(TYPE_FRE, fre_data);
    if (grant[4]) begin
      sel_word = short_word(CODE_LOCK);
    end else if (grant[3]) begin
      sel_word = short_word(CODE_SYN);
    end else if (grant[2]) begin
      sel_word = long_word(TYPE_CMD, cmd_data);
    end else if (grant[1]) begin
      sel_word = long_word(TYPE_REF, ref_data);
    end
  end

  assign data_last = long_reg ? LONG_LAST : SHORT_LAST;
  assign rep_last  = long_reg ? LONG_REP_LAST : 2'd0;

  always_comb begin
    state_next = state_reg;
    bit_next   = bit_reg;
    data_next  = data_reg;
    long_next  = long_reg;
    rep_next   = rep_reg;
    word_done  = 1'b0;
    txd_next   = 1'b1;

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_START;
          bit_next   = '0;
          rep_next   = '0;
          long_next  = ~(grant[4] | grant[3]);
          data_next  = sel_word;
        end
      end
      ST_START: begin
        if (bit_tick) begin
          state_next = ST_DATA;
          bit_next   = '0;
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          if (bit_reg == data_last) begin
            state_next = ST_STOP;
            bit_next   = '0;
          end else begin
            bit_next = bit_reg + 5'd1;
          end
        end
      end
      ST_STOP: begin
        if (bit_tick) begin
          state_next = ST_GAP;
          bit_next   = '0;
        end
      end
      ST_GAP: begin
        if (bit_tick) begin
          if (bit_reg == GAP_LAST) begin
            bit_next = '0;
            // Repeats go straight back to START; pending requests wait for IDLE.
            if (rep_reg == rep_last) begin
              state_next = ST_IDLE;
              word_done  = !rst;
            end else begin
              state_next = ST_START;
              rep_next   = rep_reg + 2'd1;
            end
          end else begin
            bit_next = bit_reg + 5'd1;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Line level is registered for the state being entered, keeping txd glitch-free.
    case (state_next)
      ST_START: txd_next = 1'b0;
      ST_DATA:  txd_next = data_next[5'd19 - bit_next];
      default:  txd_next = 1'b1;
    endcase
  end

  assign timer_clr = (state_next != state_reg);

  down_bit_timer #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (timer_clr),
    .tick (bit_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      bit_reg   <= '0;
      data_reg  <= '0;
      long_reg  <= 1'b0;
      rep_reg   <= '0;
      txd_reg   <= 1'b1;
    end else begin
      state_reg <= state_next;
      bit_reg   <= bit_next;
      data_reg  <= data_next;
      long_reg  <= long_next;
      rep_reg   <= rep_next;
      txd_reg   <= txd_next;
    end
  end

  assign txd  = txd_reg;
  assign busy = (state_reg != ST_IDLE) || accept;

endmodule

// File: tb/tb_down_frame_tx.sv
// Directed bench for down_frame_tx with BIT_CYCLES=4, GAP_BITS=2; the repeat
// count follows DOWN_TX_REPEAT_EN the same way the build does.
module tb_down_frame_tx;

  localparam int BC  = 4;
  localparam int GAP = 2;
`ifdef DOWN_TX_REPEAT_EN
  localparam int REPS = 3;
`else
  localparam int REPS = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ref_req = 1'b0, cmd_req = 1'b0, fre_req = 1'b0, syn_req = 1'b0, lock_req = 1'b0;
  logic [15:0] ref_data = '0, cmd_data = '0, fre_data = '0;
  logic        txd, busy, ref_ack, cmd_ack, fre_ack, syn_ack, lock_ack, word_done;

  int n_vec = 0;
  int n_bad = 0;

  down_frame_tx #(
    .BIT_CYCLES (BC),
    .GAP_BITS   (GAP),
    .REPEAT_N   (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ref_req   (ref_req),
    .ref_data  (ref_data),
    .cmd_req   (cmd_req),
    .cmd_data  (cmd_data),
    .fre_req   (fre_req),
    .fre_data  (fre_data),
    .syn_req   (syn_req),
    .lock_req  (lock_req),
    .txd       (txd),
    .busy      (busy),
    .ref_ack   (ref_ack),
    .cmd_ack   (cmd_ack),
    .fre_ack   (fre_ack),
    .syn_ack   (syn_ack),
    .lock_ack  (lock_ack),
    .word_done (word_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  function automatic logic [4:0] acks();
    return {lock_ack, syn_ack, cmd_ack, ref_ack, fre_ack};
  endfunction

  // sel: 0 lock, 1 syn, 2 cmd, 3 ref, 4 fre (matches ack vector order)
  task automatic set_req(input int sel, input logic v);
    case (sel)
      0: lock_req = v;
      1: syn_req  = v;
      2: cmd_req  = v;
      3: ref_req  = v;
      default: fre_req = v;
    endcase
  endtask

  task automatic set_data(input int sel, input logic [15:0] d);
    case (sel)
      2: cmd_data = d;
      3: ref_data = d;
      4: fre_data = d;
      default: ;
    endcase
  endtask

  // Waits (bounded) for any ack, then checks which one fired and busy.
  task automatic accept(input string tag, input int sel, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (acks() == 5'b00000 && waited < 2000);
    check({tag, "_ack"}, 32'(acks()), 32'(5'b10000 >> sel));
    check({tag, "_busy_acc"}, 32'(busy), 32'd1);
  endtask

  // Samples one frame plus gap, one bit per BC cycles, from the cycle after acceptance.
  task automatic frame(input string tag, input logic [31:0] exp, input int nbits, input logic last);
    logic [31:0] obs;
    int          glitch;
    int          stray;
    logic        v, wd, bz;
    obs = '0; glitch = 0; stray = 0; v = 1'b1; wd = 1'b0; bz = 1'b0;
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < BC; c++) begin
        @(negedge clk);
        if (c == 0) v = txd;
        else if (txd !== v) glitch++;
        if (acks() != 5'b00000) stray++;
        if (b == nbits - 1 && c == BC - 1) begin
          wd = word_done;
          bz = busy;
        end else if (word_done) begin
          stray++;
        end
      end
      obs = {obs[30:0], v};
    end
    $display("frame %s bits=%h", tag, obs);
    check({tag, "_bits"}, obs, exp);
    check({tag, "_stable"}, 32'(glitch), 32'd0);
    check({tag, "_stray"}, 32'(stray), 32'd0);
    check({tag, "_done"}, 32'(wd), 32'(last));
    check({tag, "_busy_end"}, 32'(bz), 32'd1);
  endtask

  task automatic long_frames(input string tag, input logic [3:0] typ, input logic [15:0] payload);
    for (int r = 0; r < REPS; r++)
      frame($sformatf("%s_r%0d", tag, r), {8'h00, 1'b0, typ, payload, 1'b1, 2'b11}, 22 + GAP, r == REPS - 1);
  endtask

  // Raise a request from idle, check ack latency, drop it and scramble its payload.
  task automatic start_word(input string tag, input int sel, input logic [15:0] payload);
    int w;
    @(posedge clk); #1;
    set_data(sel, payload);
    set_req(sel, 1'b1);
    accept(tag, sel, w);
    check({tag, "_lat"}, 32'(w), 32'd1);
    @(posedge clk); #1;
    set_req(sel, 1'b0);
    set_data(sel, ~payload);
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_txd"}, 32'(txd), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int cnt;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_acks", 32'(acks()), 32'd0);
    check("rst_done", 32'(word_done), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    idle_check("post_rst");

    // Command start word: 0,1010 0001 0001 0001 0001,1 + gap
    start_word("cmd1111", 2, 16'h1111);
    long_frames("cmd1111", 4'b1010, 16'h1111);
    idle_check("cmd1111");

    // syn and ref together: syn wins, ref follows back-to-back
    @(posedge clk); #1;
    ref_data = 16'hA55A;
    syn_req  = 1'b1;
    ref_req  = 1'b1;
    accept("syn", 1, w);
    check("syn_lat", 32'(w), 32'd1);
    @(posedge clk); #1 syn_req = 1'b0;
    frame("syn", {24'h0, 1'b0, 4'b1000, 1'b1, 2'b11}, 6 + GAP, 1'b1);
    accept("ref_pend", 3, w);
    check("ref_pend_lat", 32'(w), 32'd1);
    @(posedge clk); #1;
    ref_req  = 1'b0;
    ref_data = 16'h0000;
    long_frames("refA55A", 4'b1001, 16'hA55A);
    idle_check("refA55A");

    // fre 40000 with lock raised mid first repeat
    start_word("fre9C40", 4, 16'h9C40);
    fork
      long_frames("fre9C40", 4'b1011, 16'h9C40);
      begin
        repeat (30) @(posedge clk);
        #1 lock_req = 1'b1;
      end
    join
    accept("lock", 0, w);
    check("lock_lat", 32'(w), 32'd1);
    @(posedge clk); #1 lock_req = 1'b0;
    frame("lock", {24'h0, 1'b0, 4'b1100, 1'b1, 2'b11}, 6 + GAP, 1'b1);
    idle_check("lock");

    // Reset during DATA bit 10 abandons the frame
    start_word("cmd_abort", 2, 16'h4444);
    repeat (46) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_txd", 32'(txd), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (word_done || busy || acks() != 5'b00000 || txd !== 1'b1) cnt++;
    end
    check("abort_quiet", 32'(cnt), 32'd0);

    // Fresh command after the abort
    start_word("cmd2222", 2, 16'h2222);
    long_frames("cmd2222", 4'b1010, 16'h2222);
    idle_check("cmd2222");

    // Reference 0x0005 with payload changed right after ack
    start_word("ref0005", 3, 16'h0005);
    long_frames("ref0005", 4'b1001, 16'h0005);
    idle_check("ref0005");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
